// File: rtl/lsu_dmem_ctrl_if.sv
// Request/response handshake plus RAM data-port bus for the LSU memory stage.
// slave = the LSU itself; master = execute stage / RAM side.
interface lsu_dmem_ctrl_if #(parameter int XLEN = 64);
  logic            req_valid;
  logic            req_ready;
  logic            req_wen;
  logic [1:0]      req_size;
  logic            req_unsigned;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_misalign;
  logic            dmem_en;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_rdata;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_wmask;
  logic            dmem_wen;

  modport slave (
    input  req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
           resp_ready, dmem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_misalign,
           dmem_en, dmem_addr, dmem_wdata, dmem_wmask, dmem_wen
  );

  modport master (
    output req_valid, req_wen, req_size, req_unsigned, req_addr, req_wdata,
           resp_ready, dmem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_misalign,
           dmem_en, dmem_addr, dmem_wdata, dmem_wmask, dmem_wen
  );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// LSU memory stage: one aligned 64-bit RAM access per request, lane-aligned stores,
// extended loads. Define LSU_MISALIGN_CHECK_EN to trap misaligned requests instead of aligning them.
module lsu_dmem_ctrl #(
  parameter int XLEN = 64
) (
  input logic            clk,
  input logic            rst,
  lsu_dmem_ctrl_if.slave bus
);
  localparam int LANES = XLEN / 8;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic            wen;
    logic [1:0]      size;
    logic            uns;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
  } lsu_req_t;

  state_t          st, nxt;
  lsu_req_t        lat;
  logic [XLEN-1:0] rdata_q;
  logic            mis_q;
  logic            mis_chk;
  logic            acc;
  logic [2:0]      off;
  logic [LANES-1:0] bmask;
  logic [XLEN-1:0] sh;
  logic [XLEN-1:0] ld;

`ifdef LSU_MISALIGN_CHECK_EN
  always_comb begin
    case (bus.req_size)
      2'd1:    mis_chk = bus.req_addr[0];
      2'd2:    mis_chk = |bus.req_addr[1:0];
      2'd3:    mis_chk = |bus.req_addr[2:0];
      default: mis_chk = 1'b0;
    endcase
  end
  assign off = lat.addr[2:0];
`else
  assign mis_chk = 1'b0;
  // Misaligned offsets are rounded down to the access size's natural boundary.
  always_comb begin
    case (lat.size)
      2'd1:    off = {lat.addr[2:1], 1'b0};
      2'd2:    off = {lat.addr[2], 2'b00};
      2'd3:    off = 3'b000;
      default: off = lat.addr[2:0];
    endcase
  end
`endif

  always_comb begin
    nxt           = st;
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b0;
    acc           = 1'b0;
    case (st)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) nxt = mis_chk ? RESP : ACCESS;
      end
      ACCESS: begin
        acc = 1'b1;
        nxt = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    case (lat.size)
      2'd0:    bmask = 8'h01 << off;
      2'd1:    bmask = 8'h03 << off;
      2'd2:    bmask = 8'h0F << off;
      default: bmask = 8'hFF;
    endcase
  end

  // Enables are also gated by rst so a reset mid-access can never commit a write.
  assign bus.dmem_en    = acc & ~rst;
  assign bus.dmem_wen   = acc & ~rst & lat.wen;
  assign bus.dmem_addr  = {lat.addr[XLEN-1:3], 3'b000};
  assign bus.dmem_wdata = acc ? (lat.wdata << {off, 3'b000}) : '0;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign bus.dmem_wmask[8*g +: 8] = {8{acc & bmask[g]}};
  end

  assign sh = bus.dmem_rdata >> {off, 3'b000};

  always_comb begin
    case (lat.size)
      2'd0:    ld = lat.uns ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    ld = lat.uns ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    ld = lat.uns ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: ld = sh;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= IDLE;
      lat     <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      st <= nxt;
      if (st == IDLE && bus.req_valid) begin
        lat     <= '{wen: bus.req_wen, size: bus.req_size, uns: bus.req_unsigned,
                     addr: bus.req_addr, wdata: bus.req_wdata};
        mis_q   <= mis_chk;
        rdata_q <= '0;
      end
      if (st == ACCESS) rdata_q <= lat.wen ? '0 : ld;
    end
  end

  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_misalign = mis_q;
endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Scoreboarded bench for lsu_dmem_ctrl: directed requests, behavioural RAM, decoupled monitor.
module tb_lsu_dmem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  lsu_dmem_ctrl_if #(.XLEN(64)) bus ();
  lsu_dmem_ctrl #(.XLEN(64)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [63:0] mem [0:15];
  assign bus.dmem_rdata = mem[bus.dmem_addr[6:3]];
  always @(posedge clk)
    if (bus.dmem_en && bus.dmem_wen)
      mem[bus.dmem_addr[6:3]] <= (mem[bus.dmem_addr[6:3]] & ~bus.dmem_wmask) |
                                 (bus.dmem_wdata & bus.dmem_wmask);

  typedef struct { logic [63:0] addr; logic [63:0] wdata; logic [63:0] wmask; logic wen; } acc_t;
  typedef struct { logic [63:0] rdata; logic mis; } rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: compare every RAM access and every response handshake against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.dmem_en) begin
        if (acc_q.size() == 0) timeout("unexpected dmem access");
        else begin
          acc_t a;
          a = acc_q.pop_front();
          check("dmem_addr",  bus.dmem_addr,  a.addr);
          check("dmem_wdata", bus.dmem_wdata, a.wdata);
          check("dmem_wmask", bus.dmem_wmask, a.wmask);
          check("dmem_wen",   {63'b0, bus.dmem_wen}, {63'b0, a.wen});
        end
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (rsp_q.size() == 0) timeout("unexpected response");
        else begin
          rsp_t r;
          r = rsp_q.pop_front();
          check("resp_rdata",    bus.resp_rdata, r.rdata);
          check("resp_misalign", {63'b0, bus.resp_misalign}, {63'b0, r.mis});
        end
      end
    end
  end

  task automatic drive(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata);
    bus.req_valid = 1'b1; bus.req_wen = wen; bus.req_size = size;
    bus.req_unsigned = uns; bus.req_addr = addr; bus.req_wdata = wdata;
  endtask

  task automatic expect_req(input logic [63:0] addr, input logic has_acc, input logic wen,
                            input logic [63:0] wdata, input logic [63:0] wmask,
                            input logic [63:0] rdata, input logic mis);
    if (has_acc) acc_q.push_back('{addr: addr & ~64'h7, wdata: wdata, wmask: wmask, wen: wen});
    rsp_q.push_back('{rdata: rdata, mis: mis});
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ready && n < 20);
    if (n >= 20) timeout("accept");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic finish_resp(input int exp_lat);
    int n = 0;
    do begin @(negedge clk); n++; end while (!bus.resp_valid && n < 20);
    check("resp latency", 64'(n), 64'(exp_lat));
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic has_acc, input logic [63:0] exp_wdata,
                       input logic [63:0] exp_wmask, input logic [63:0] exp_rdata,
                       input logic exp_mis, input int exp_lat);
    expect_req(addr, has_acc, wen, exp_wdata, exp_wmask, exp_rdata, exp_mis);
    drive(wen, size, uns, addr, wdata);
    wait_accept();
    finish_resp(exp_lat);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;
    #1;
    check("rst req_ready",  {63'b0, bus.req_ready},  64'd1);
    check("rst resp_valid", {63'b0, bus.resp_valid}, 64'd0);
    check("rst resp_rdata", bus.resp_rdata, 64'd0);
    check("rst dmem_en",    {63'b0, bus.dmem_en},    64'd0);
    check("rst dmem_addr",  bus.dmem_addr,  64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // wen size uns addr wdata | acc exp_wdata exp_wmask | exp_rdata mis lat
    issue(1, 3, 0, 64'h80000010, 64'h1122334455667788,
          1, 64'h1122334455667788, 64'hFFFFFFFFFFFFFFFF, 64'h0, 0, 2);
    issue(1, 0, 0, 64'h80000013, 64'h00000000000000AB,
          1, 64'h00000000AB000000, 64'h00000000FF000000, 64'h0, 0, 2);
    issue(0, 3, 0, 64'h80000010, 64'h0,
          1, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h11223344AB667788, 0, 2);
    issue(1, 3, 0, 64'h80000010, 64'h8001000000000000,
          1, 64'h8001000000000000, 64'hFFFFFFFFFFFFFFFF, 64'h0, 0, 2);
    issue(0, 1, 0, 64'h80000016, 64'h0,
          1, 64'h0, 64'hFFFF000000000000, 64'hFFFFFFFFFFFF8001, 0, 2);
    issue(0, 1, 1, 64'h80000016, 64'h0,
          1, 64'h0, 64'hFFFF000000000000, 64'h0000000000008001, 0, 2);
    issue(0, 0, 0, 64'h80000017, 64'h0,
          1, 64'h0, 64'hFF00000000000000, 64'hFFFFFFFFFFFFFF80, 0, 2);
    issue(1, 3, 0, 64'h80000000, 64'hCAFEF00D87654321,
          1, 64'hCAFEF00D87654321, 64'hFFFFFFFFFFFFFFFF, 64'h0, 0, 2);
`ifdef LSU_MISALIGN_CHECK_EN
    issue(0, 2, 0, 64'h80000002, 64'h0,
          0, 64'h0, 64'h0, 64'h0, 1, 1);
`else
    issue(0, 2, 0, 64'h80000002, 64'h0,
          1, 64'h0, 64'h00000000FFFFFFFF, 64'hFFFFFFFF87654321, 0, 2);
`endif
    issue(0, 2, 1, 64'h80000004, 64'h0,
          1, 64'h0, 64'hFFFFFFFF00000000, 64'h00000000CAFEF00D, 0, 2);

    // Back-pressure: hold resp_ready low while a second request waits.
    bus.resp_ready = 1'b0;
    expect_req(64'h80000000, 1, 0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hCAFEF00D87654321, 0);
    drive(0, 3, 0, 64'h80000000, 64'h0);
    wait_accept();
    expect_req(64'h80000020, 1, 1, 64'h0000000000005555, 64'hFFFFFFFFFFFFFFFF, 64'h0, 0);
    drive(1, 3, 0, 64'h80000020, 64'h0000000000005555);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall resp_valid", {63'b0, bus.resp_valid}, 64'd1);
      check("stall resp_rdata", bus.resp_rdata, 64'hCAFEF00D87654321);
      check("stall req_ready",  {63'b0, bus.req_ready}, 64'd0);
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b1;
    wait_accept();
    finish_resp(2);

    // Reset in the middle of a store's access cycle.
    drive(1, 3, 0, 64'h80000020, 64'h000000000000DEAD);
    wait_accept();
    rst = 1'b1;
    #1;
    check("mid-rst dmem_en",    {63'b0, bus.dmem_en},    64'd0);
    check("mid-rst dmem_wen",   {63'b0, bus.dmem_wen},   64'd0);
    check("mid-rst dmem_wmask", bus.dmem_wmask, 64'd0);
    check("mid-rst dmem_wdata", bus.dmem_wdata, 64'd0);
    check("mid-rst dmem_addr",  bus.dmem_addr,  64'd0);
    check("mid-rst req_ready",  {63'b0, bus.req_ready},  64'd1);
    check("mid-rst resp_valid", {63'b0, bus.resp_valid}, 64'd0);
    @(posedge clk); #1;
    check("mid-rst ram word", mem[4], 64'h0000000000005555);
    rst = 1'b0;
    issue(0, 3, 0, 64'h80000020, 64'h0,
          1, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000005555, 0, 2);

    repeat (3) @(posedge clk);
    check("acc queue drained", 64'(acc_q.size()), 64'd0);
    check("rsp queue drained", 64'(rsp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lsu_dmem_ctrl.md
# lsu_dmem_ctrl

Load/store unit memory stage that sits directly upstream of the 2-read/1-write simulation RAM's data port and drives its `dmem_*` signals. Accepts one load or store request at a time from the execute stage through a valid/ready handshake and issues exactly one aligned 64-bit RAM access per request. Lane-aligns store data into a byte mask and extracts and extends load data. Returns a registered response through a second valid/ready handshake.

## Interface
Parameters:
- `XLEN`, 64: data and address width. Only 64 is supported.

Ports:
- `clk`  in  1  clock; all state updates on its rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_wen`  in  1  1 = store, 0 = load
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `req_addr`  in  64  byte address
- `req_wdata`  in  64  store data, right-justified
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  consumer accepts response
- `resp_rdata`  out  64  extended load data; 0 for stores
- `resp_misalign`  out  1  request was misaligned and was not performed
- `dmem_en`  out  1  RAM access enable
- `dmem_addr`  out  64  RAM byte address, always 8-byte aligned
- `dmem_rdata`  in  64  RAM read data, combinational from `dmem_addr`
- `dmem_wdata`  out  64  lane-shifted store data
- `dmem_wmask`  out  64  bit mask; each byte lane is all-0 or 0xFF
- `dmem_wen`  out  1  RAM write enable; RAM commits at the `clk` edge

## Operation
- FSM with three states: IDLE, ACCESS, RESP.
- Reset state is IDLE.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, latch wen/size/unsigned/addr/wdata.
  - Next state is ACCESS. It is RESP instead when the request is misaligned and misalign checking is compiled in.
- ACCESS (exactly one cycle):
  - `dmem_en` = 1 and `dmem_addr` = {addr[63:3], 3'b000}.
  - `dmem_wen` = latched wen.
  - Offset `off` = addr[2:0].
  - `dmem_wdata` = wdata << (8*off).
  - Byte mask: B = 1 lane, H = 2, W = 4, D = 8, shifted left by `off`. `dmem_wmask` is this mask expanded to bits.
  - Loads: at the closing edge, `resp_rdata` is registered as (`dmem_rdata` >> 8*off), truncated to the size, then sign- or zero-extended.
  - Stores: `resp_rdata` is registered as 0.
  - Next state is RESP.
- RESP:
  - `resp_valid` = 1.
  - `resp_rdata` and `resp_misalign` are held stable.
  - Stays in RESP until `resp_ready` = 1, then goes to IDLE.
- Outside ACCESS: `dmem_en`, `dmem_wen`, `dmem_wmask` and `dmem_wdata` are 0, and `dmem_addr` holds the last latched aligned address.
- Misaligned means: H with addr[0]≠0, W with addr[1:0]≠0, D with addr[2:0]≠0. Byte accesses are never misaligned.
- `req_ready` is 0 outside IDLE. `req_valid` presented then is ignored and is not latched.

## Timing
- Request accepted at edge N.
- ACCESS occupies cycle N..N+1. A store commits at edge N+1.
- `resp_valid` rises after edge N+1.
- Earliest next accept is the edge after the `resp_ready` handshake, so peak throughput is 1 request per 3 cycles.
- Misaligned request (check compiled in): `resp_valid` rises after edge N. No `dmem_en` pulse occurs.
- Reset values: state IDLE, `req_ready` 1, `resp_valid` 0, `resp_rdata` 0, `resp_misalign` 0, `dmem_en` 0, `dmem_wen` 0, `dmem_wmask` 0, `dmem_wdata` 0, `dmem_addr` 0.
- Reset asserted mid-ACCESS: `dmem_en` and `dmem_wen` drop combinationally. No write commits, and the FSM is in IDLE on deassertion.
- Reset asserted in RESP: the response is discarded.
- `resp_ready` is sampled only in RESP. A 1 seen in other states has no effect.

## Configuration
- `LSU_MISALIGN_CHECK_EN` defined:
  - Misaligned requests skip ACCESS.
  - They return `resp_misalign` = 1 with `resp_rdata` = 0.
  - RAM is untouched.
- Not defined:
  - `resp_misalign` is tied to 0.
  - `off` is forced to natural alignment: H clears bit 0, W clears bits 1:0, D clears bits 2:0.
  - The access proceeds normally.

## Test plan
- Store D 0x1122334455667788 at 0x80000010 -> ACCESS: `dmem_addr` 0x80000010, `dmem_wmask` all-ones, `dmem_wen` 1; RESP: `resp_rdata` 0.
- Store B 0xAB at 0x80000013 -> `dmem_wdata` 0x00000000AB000000, `dmem_wmask` 0x00000000FF000000, `dmem_addr` 0x80000010.
- Load H at 0x80000016 with `dmem_rdata` 0x8001000000000000 -> signed: `resp_rdata` 0xFFFFFFFFFFFF8001; unsigned: 0x0000000000008001.
- Load W at 0x80000002:
  - With `LSU_MISALIGN_CHECK_EN`: no `dmem_en`, `resp_valid` one cycle after accept, `resp_misalign` 1, `resp_rdata` 0.
  - Without it: access at 0x80000000, `off` 0.
- Hold `resp_ready` 0 for 5 cycles with `req_valid` 1 -> `resp_valid`/`resp_rdata` stable, `req_ready` 0, and the second request is accepted only after the handshake.
- Assert `rst` during ACCESS of a store -> `dmem_wen` drops immediately, RAM contents unchanged, and all outputs at their reset values.
